threshold_cv_mac_pipe: RTL and testbench

Parametrised, handshaked pipelined multiply / multiply-accumulate unit for the threshold_cv accelerator datapath. It generalises the fixed 16x16->32 clock-enabled multiplier in four ways: configurable operand and result widths, per-operand signedness, configurable pipeline depth, and an optional accumulate mode that sums products across a burst. Valid/ready flow control lets it sit directly between stream FIFOs in the pixel pipeline, with global stall under backpressure.

---
 rtl/threshold_cv_mul_pkg.sv | 19 +
 rtl/threshold_cv_mul_stage_pipe.sv | 117 +++++++++++
 rtl/threshold_cv_mac_pipe.sv | 115 +++++++++++
 tb/tb_threshold_cv_mac_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/threshold_cv_mul_pkg.sv
// Shared types and helpers for the threshold_cv multiply / MAC pipeline.
// Pure declarations: no latency, no flow control.
package threshold_cv_mul_pkg;

    localparam int NUM_STAGE_MIN = 2;
    localparam int NUM_STAGE_MAX = 8;

    // Control half of a pipeline token; the product travels beside it because its width is a parameter.
    typedef struct packed {
        logic vld;
        logic acc_en;
        logic acc_last;
    } tok_ctl_t;

    function automatic int MUL_WIDTH(input int a, input int b);
        return a + b + 1;
    endfunction

endpackage

// File: rtl/threshold_cv_mul_stage_pipe.sv
// Operand register, extend/multiply and retiming registers: NUM_STAGE-1 cycles of latency.
// Backpressure: every stage holds while adv=0, and all stages shift together while adv=1.
module threshold_cv_mul_stage_pipe
    import threshold_cv_mul_pkg::*;
#(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int P_WIDTH   = 32,
    parameter int NUM_STAGE = 4,
    parameter int A_SIGNED  = 0,
    parameter int B_SIGNED  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               adv,
    input  logic               in_vld,
    input  logic [A_WIDTH-1:0] din0,
    input  logic [B_WIDTH-1:0] din1,
    input  logic               acc_en,
    input  logic               acc_last,
    output logic [P_WIDTH-1:0] prod,
    output tok_ctl_t           ctl,
    output logic               any_vld
);

    localparam int MW = MUL_WIDTH(A_WIDTH, B_WIDTH);
    localparam int NR = NUM_STAGE - 1;

    logic [A_WIDTH-1:0] a_q, a_d;
    logic [B_WIDTH-1:0] b_q, b_d;
    tok_ctl_t           ctl1_q, ctl1_d;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        ctl1_d = ctl1_q;
        if (adv) begin
            a_d             = din0;
            b_d             = din1;
            ctl1_d.vld      = in_vld;
            ctl1_d.acc_en   = acc_en;
            ctl1_d.acc_last = acc_last & acc_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            ctl1_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            ctl1_q <= ctl1_d;
        end
    end

    // Both operands are widened to the full product width so one signed multiply covers all signedness mixes.
    logic signed [MW-1:0] a_ext, b_ext, full;

    assign a_ext = {{(MW - A_WIDTH){(A_SIGNED != 0) && a_q[A_WIDTH-1]}}, a_q};
    assign b_ext = {{(MW - B_WIDTH){(B_SIGNED != 0) && b_q[B_WIDTH-1]}}, b_q};
    assign full  = a_ext * b_ext;

    logic [P_WIDTH-1:0] prod_s [NR];
    tok_ctl_t           ctl_s  [NR];

    if (P_WIDTH < MW) begin : g_trunc
        logic prod_hi_unused;
        assign prod_s[0]      = full[P_WIDTH-1:0];
        assign prod_hi_unused = ^full[MW-1:P_WIDTH];
    end else if (P_WIDTH == MW) begin : g_exact
        assign prod_s[0] = full;
    end else begin : g_sext
        assign prod_s[0] = {{(P_WIDTH - MW){full[MW-1]}}, full};
    end

    assign ctl_s[0] = ctl1_q;

    for (genvar k = 1; k < NR; k++) begin : g_ret
        logic [P_WIDTH-1:0] prod_q, prod_d;
        tok_ctl_t           ctl_q, ctl_d;

        always_comb begin
            prod_d = prod_q;
            ctl_d  = ctl_q;
            if (adv) begin
                prod_d = prod_s[k-1];
                ctl_d  = ctl_s[k-1];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                prod_q <= '0;
                ctl_q  <= '0;
            end else begin
                prod_q <= prod_d;
                ctl_q  <= ctl_d;
            end
        end

        assign prod_s[k] = prod_q;
        assign ctl_s[k]  = ctl_q;
    end

    assign prod = prod_s[NR-1];
    assign ctl  = ctl_s[NR-1];

    always_comb begin
        any_vld = 1'b0;
        for (int k = 0; k < NR; k++) begin
            any_vld = any_vld | ctl_s[k].vld;
        end
    end

endmodule

// File: rtl/threshold_cv_mac_pipe.sv
// Handshaked multiply / multiply-accumulate: result NUM_STAGE advancing cycles after accept.
// Backpressure: a held result with out_ready=0, or ce=0, stalls every stage and drops in_ready.
module threshold_cv_mac_pipe
    import threshold_cv_mul_pkg::*;
#(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int P_WIDTH   = 32,
    parameter int NUM_STAGE = 4,
    parameter int A_SIGNED  = 0,
    parameter int B_SIGNED  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] din0,
    input  logic [B_WIDTH-1:0] din1,
    input  logic               acc_en,
    input  logic               acc_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] dout,
    output logic               busy
);

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX || P_WIDTH < 1) begin : g_bad_param
        $error("threshold_cv_mac_pipe: NUM_STAGE must be 2..8 and P_WIDTH >= 1");
    end

    logic               advance;
    logic               accept;
    logic [P_WIDTH-1:0] pipe_prod;
    tok_ctl_t           pipe_ctl;
    logic               pipe_any_vld;

    logic               out_valid_q, out_valid_d;
    logic [P_WIDTH-1:0] dout_q, dout_d;
    logic [P_WIDTH-1:0] acc_q, acc_d;
    logic               acc_open_q, acc_open_d;
    logic [P_WIDTH-1:0] acc_sum;

    assign advance  = ce & (~out_valid_q | out_ready);
    assign in_ready = advance;
    assign accept   = in_valid & advance;

    threshold_cv_mul_stage_pipe #(
        .A_WIDTH   (A_WIDTH),
        .B_WIDTH   (B_WIDTH),
        .P_WIDTH   (P_WIDTH),
        .NUM_STAGE (NUM_STAGE),
        .A_SIGNED  (A_SIGNED),
        .B_SIGNED  (B_SIGNED)
    ) u_mul (
        .clk      (clk),
        .reset    (reset),
        .adv      (advance),
        .in_vld   (accept),
        .din0     (din0),
        .din1     (din1),
        .acc_en   (acc_en),
        .acc_last (acc_last),
        .prod     (pipe_prod),
        .ctl      (pipe_ctl),
        .any_vld  (pipe_any_vld)
    );

    // Sum wraps at P_WIDTH bits by construction.
    assign acc_sum = acc_q + pipe_prod;

    always_comb begin
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        acc_d       = acc_q;
        acc_open_d  = acc_open_q;
        if (advance) begin
            // advance implies the held result (if any) is being popped this cycle.
            out_valid_d = 1'b0;
            if (pipe_ctl.vld) begin
                if (!pipe_ctl.acc_en) begin
                    dout_d      = pipe_prod;
                    out_valid_d = 1'b1;
                end else if (!pipe_ctl.acc_last) begin
                    acc_d      = acc_sum;
                    acc_open_d = 1'b1;
                end else begin
                    dout_d      = acc_sum;
                    acc_d       = '0;
                    acc_open_d  = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            acc_q       <= '0;
            acc_open_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            acc_q       <= acc_d;
            acc_open_q  <= acc_open_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign busy      = pipe_any_vld | out_valid_q | acc_open_q;

endmodule

// File: tb/tb_threshold_cv_mac_pipe.sv
// Bench for threshold_cv_mac_pipe: default unsigned 16x16 instance plus a signed 8x8 two-stage instance.
// Expected results are queued when a beat is accepted and compared when the DUT pops a result.
module tb_threshold_cv_mac_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        out_ready = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] din0 = '0, din1 = '0;
    logic        acc_en = 1'b0, acc_last = 1'b0;
    logic        in_ready, out_valid, busy;
    logic [31:0] dout;

    logic        in_valid_s = 1'b0;
    logic [7:0]  din0_s = '0, din1_s = '0;
    logic        in_ready_s, out_valid_s, busy_s;
    logic [15:0] dout_s;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];
    logic [15:0] exp_s_q [$];
    logic [31:0] macc = '0;
    logic [63:0] mon_p;
    int          mon_s;
    logic [31:0] mon_e;
    logic [15:0] mon_es;

    always #5 clk = ~clk;

    threshold_cv_mac_pipe dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .acc_en(acc_en), .acc_last(acc_last),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy)
    );

    threshold_cv_mac_pipe #(
        .A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(16), .NUM_STAGE(2), .A_SIGNED(1), .B_SIGNED(1)
    ) dut_s (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .din0(din0_s), .din1(din1_s), .acc_en(1'b0), .acc_last(1'b0),
        .out_valid(out_valid_s), .out_ready(out_ready), .dout(dout_s), .busy(busy_s)
    );

    // Scoreboard: push on accept, pop on result handshake (both seen half a cycle before the edge).
    always @(negedge clk) begin
        if (!reset) begin
            if (in_valid && in_ready) begin
                mon_p = 64'(din0) * 64'(din1);
                if (!acc_en) exp_q.push_back(mon_p[31:0]);
                else if (!acc_last) macc = macc + mon_p[31:0];
                else begin
                    exp_q.push_back(macc + mon_p[31:0]);
                    macc = '0;
                end
            end
            if (in_valid_s && in_ready_s) begin
                mon_s = int'($signed(din0_s)) * int'($signed(din1_s));
                exp_s_q.push_back(mon_s[15:0]);
            end
            if (ce && out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: dout=%h with nothing expected", dout);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (dout !== mon_e) begin
                        n_fail++;
                        $display("FAIL sb_dout: got %h expected %h", dout, mon_e);
                    end
                end
            end
            if (ce && out_valid_s && out_ready) begin
                n_tests++;
                if (exp_s_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_s_unexpected: dout_s=%h with nothing expected", dout_s);
                end else begin
                    mon_es = exp_s_q.pop_front();
                    if (dout_s !== mon_es) begin
                        n_fail++;
                        $display("FAIL sb_s_dout: got %h expected %h", dout_s, mon_es);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic en, input logic last);
        int w;
        din0 = a; din1 = b; acc_en = en; acc_last = last; in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; acc_en = 1'b0; acc_last = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b1; out_ready = 1'b1;
        tick(); tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (dout !== 32'h0) begin n_fail++; $display("FAIL rst_dout: got %h expected 0", dout); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_ce1: got %b expected 1", in_ready); end
        ce = 1'b0; #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_ce0: got %b expected 0", in_ready); end
        ce = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        send(16'd3, 16'd5, 1'b0, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        idle();
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: out_valid=%b expected 0", out_valid); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || dout !== 32'd15) begin n_fail++; $display("FAIL basic_first: out_valid=%b dout=%h expected 1/0000000f", out_valid, dout); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || dout !== 32'hFFFE0001) begin n_fail++; $display("FAIL basic_second: out_valid=%b dout=%h expected 1/fffe0001", out_valid, dout); end
        repeat (3) tick();
    endtask

    task automatic test_signed();
        in_valid_s = 1'b1; din0_s = 8'h80; din1_s = 8'h80;
        tick();
        din0_s = 8'hFD; din1_s = 8'h07;
        tick();
        in_valid_s = 1'b0;
        n_tests++; if (out_valid_s !== 1'b1 || dout_s !== 16'h4000) begin n_fail++; $display("FAIL signed_m128sq: out_valid=%b dout=%h expected 1/4000", out_valid_s, dout_s); end
        tick();
        n_tests++; if (out_valid_s !== 1'b1 || dout_s !== 16'hFFEB) begin n_fail++; $display("FAIL signed_m3x7: out_valid=%b dout=%h expected 1/ffeb", out_valid_s, dout_s); end
        repeat (2) tick();
    endtask

    task automatic test_accum();
        int w;
        send(16'd2, 16'd3, 1'b1, 1'b0);
        send(16'd4, 16'd5, 1'b1, 1'b0);
        send(16'd1, 16'd1, 1'b1, 1'b1);
        idle();
        tick();
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL acc_beat1: out_valid=%b busy=%b expected 0/1", out_valid, busy); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL acc_beat2: out_valid=%b expected 0", out_valid); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || dout !== 32'd27) begin n_fail++; $display("FAIL acc_sum: out_valid=%b dout=%0d expected 1/27", out_valid, dout); end
        // Interleaved plain beat inside an open burst, then a one-beat burst that must see a cleared acc.
        send(16'd2, 16'd3, 1'b1, 1'b0);
        send(16'd7, 16'd7, 1'b0, 1'b0);
        send(16'd1, 16'd2, 1'b1, 1'b1);
        send(16'd2, 16'd2, 1'b1, 1'b1);
        idle();
        w = 0;
        while (busy && w < 50) begin w++; tick(); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL acc_idle_busy: busy=%b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        fork
            begin
                for (int i = 0; i < 30; i++)
                    send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b0, 1'b0);
                idle();
            end
            begin
                repeat (8) tick();
                out_ready = 1'b0;
                @(negedge clk);
                held = dout;
                for (int k = 0; k < 9; k++) begin
                    @(negedge clk);
                    n_tests++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || dout !== held) begin
                        n_fail++;
                        $display("FAIL bp_hold: in_ready=%b out_valid=%b dout=%h expected 0/1/%h", in_ready, out_valid, dout, held);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    n_tests++;
                    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL bp_rate: in_ready=%b out_valid=%b expected 1/1", in_ready, out_valid);
                    end
                end
            end
        join
        repeat (6) tick();
    endtask

    task automatic test_ce();
        send(16'd100, 16'd200, 1'b0, 1'b0);
        send(16'hFFFF, 16'd2, 1'b0, 1'b0);
        send(16'h1234, 16'h0010, 1'b0, 1'b0);
        idle();
        tick();
        chk("ce_first", dout, 32'd20000);
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || dout !== 32'd20000 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL ce_frozen: in_ready=%b out_valid=%b dout=%h busy=%b expected 0/1/00004e20/1", in_ready, out_valid, dout, busy);
            end
            @(posedge clk);
            #1;
        end
        ce = 1'b1;
        chk("ce_still_first", dout, 32'd20000);
        tick();
        chk("ce_second_delayed", dout, 32'h0001FFFE);
        tick();
        chk("ce_third", dout, 32'h00012340);
        repeat (3) tick();
    endtask

    task automatic test_reset_burst();
        int w;
        send(16'd2, 16'd3, 1'b1, 1'b0);
        send(16'd4, 16'd5, 1'b1, 1'b0);
        idle();
        repeat (3) tick();
        chk("rb_busy_open", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rb_cleared: out_valid=%b busy=%b expected 0/0", out_valid, busy); end
        macc = '0;
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        send(16'd1, 16'd1, 1'b1, 1'b1);
        idle();
        w = 0;
        while (!out_valid && w < 20) begin w++; tick(); end
        n_tests++; if (out_valid !== 1'b1 || dout !== 32'd1) begin n_fail++; $display("FAIL rb_fresh_sum: out_valid=%b dout=%h expected 1/00000001", out_valid, dout); end
        repeat (3) tick();
    endtask

    initial begin
        int w;
        test_reset();
        test_basic();
        test_signed();
        test_accum();
        test_backpressure();
        test_ce();
        test_reset_burst();
        w = 0;
        while ((exp_q.size() != 0 || exp_s_q.size() != 0 || busy) && w < 100) begin w++; tick(); end
        n_tests++;
        if (exp_q.size() != 0 || exp_s_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d pending_s=%0d busy=%b expected 0/0/0", exp_q.size(), exp_s_q.size(), busy);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
